// File: rtl/rx_cmd_ctrl.sv
// Command packet parser behind the UART byte receiver: loads the matcher pattern bank and streams text through a FIFO.
// Optional feature macro: RX_CMD_CHECKSUM_EN adds a trailing XOR checksum byte (CHK state).
module rx_cmd_ctrl #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         PAT_MAX      = 32,
    parameter int         PAT_AW       = 5,
    parameter int         FIFO_AW      = 4,
    parameter int         TIMEOUT_CLKS = 20000
) (
    input  logic              clk_s,
    input  logic              rstn_s,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    output logic              pat_we,
    output logic [PAT_AW-1:0] pat_addr,
    output logic [7:0]        pat_wdata,
    output logic [7:0]        pat_len,
    output logic              pat_valid,
    output logic [7:0]        txt_data,
    output logic              txt_last,
    output logic              txt_valid,
    input  logic              txt_ready,
    output logic              busy,
    output logic              err,
    output logic [2:0]        err_code
);

    localparam logic [7:0]  CMD_LOAD  = 8'h01;
    localparam logic [7:0]  CMD_TEXT  = 8'h02;
    localparam logic [7:0]  CMD_CLEAR = 8'h03;
    localparam logic [2:0]  E_BAD_CMD  = 3'd1;
    localparam logic [2:0]  E_BAD_LEN  = 3'd2;
    localparam logic [2:0]  E_OVERFLOW = 3'd3;
    localparam logic [2:0]  E_TIMEOUT  = 3'd4;
    localparam logic [7:0]  PAT_MAX_B  = 8'(PAT_MAX);
    localparam logic [15:0] TIMEOUT_B  = 16'(TIMEOUT_CLKS);
    localparam int          DEPTH      = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] PTR_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_LEN,
`ifdef RX_CMD_CHECKSUM_EN
        S_CHK,
`endif
        S_PAYLOAD
    } state_t;

    state_t       state_q, state_d;
    logic         is_load_q, is_load_d;
    logic [7:0]   len_q, len_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [15:0]  gap_q, gap_d;
    logic              pat_we_d;
    logic [PAT_AW-1:0] pat_addr_d;
    logic [7:0]        pat_wdata_d;
    logic [7:0]        pat_len_d;
    logic              pat_valid_d;
    logic              err_d;
    logic [2:0]        err_code_d;
    logic              last_byte;
    logic              push_req, push_last, do_push, pop;
    logic              full, empty;
    logic [FIFO_AW:0]  wr_q, rd_q;
    logic [8:0]        fifo_mem [DEPTH];
    logic [8:0]        head;
`ifdef RX_CMD_CHECKSUM_EN
    logic [7:0]   chk_q, chk_d;
`else
    logic         commit_q, commit_d;
`endif

    // Wrap bit distinguishes full from empty when the index bits match.
    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[FIFO_AW] != rd_q[FIFO_AW]) &&
                     (wr_q[FIFO_AW-1:0] == rd_q[FIFO_AW-1:0]);
    assign do_push = push_req && !full;
    assign pop     = !empty && txt_ready;
    assign head    = fifo_mem[rd_q[FIFO_AW-1:0]];

    assign txt_valid = !empty;
    assign txt_data  = empty ? 8'h00 : head[7:0];
    assign txt_last  = empty ? 1'b0  : head[8];
    assign busy      = (state_q != S_IDLE);
    assign last_byte = (cnt_q == len_q - 8'd1);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        is_load_d   = is_load_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        pat_we_d    = 1'b0;
        pat_addr_d  = pat_addr;
        pat_wdata_d = pat_wdata;
        pat_len_d   = pat_len;
        pat_valid_d = pat_valid;
        err_d       = 1'b0;
        err_code_d  = err_code;
        push_req    = 1'b0;
        push_last   = 1'b0;
`ifdef RX_CMD_CHECKSUM_EN
        chk_d       = chk_q;
`else
        commit_d    = 1'b0;
        if (commit_q) begin
            pat_valid_d = 1'b1;
            pat_len_d   = len_q;
        end
`endif

        if (state_q == S_IDLE || rx_done) begin
            gap_d = '0;
        end else if (gap_q == TIMEOUT_B - 16'd1) begin
            gap_d      = '0;
            err_d      = 1'b1;
            err_code_d = E_TIMEOUT;
            state_d    = S_IDLE;
        end else begin
            gap_d = gap_q + 16'd1;
        end

        if (rx_done) begin
            case (state_q)
                S_IDLE: begin
                    if (rx_data == SYNC_BYTE) state_d = S_CMD;
                end
                S_CMD: begin
                    if (rx_data == CMD_CLEAR) begin
                        pat_valid_d = 1'b0;
                        pat_len_d   = '0;
                        state_d     = S_IDLE;
                    end else if (rx_data == CMD_LOAD || rx_data == CMD_TEXT) begin
                        is_load_d = (rx_data == CMD_LOAD);
                        state_d   = S_LEN;
`ifdef RX_CMD_CHECKSUM_EN
                        chk_d     = rx_data;
`endif
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = E_BAD_CMD;
                        state_d    = S_IDLE;
                    end
                end
                S_LEN: begin
                    if (rx_data == 8'd0 || (is_load_q && rx_data > PAT_MAX_B)) begin
                        err_d      = 1'b1;
                        err_code_d = E_BAD_LEN;
                        state_d    = S_IDLE;
                    end else begin
                        len_d   = rx_data;
                        cnt_d   = '0;
                        state_d = S_PAYLOAD;
                        if (is_load_q) pat_valid_d = 1'b0;
`ifdef RX_CMD_CHECKSUM_EN
                        chk_d   = chk_q ^ rx_data;
`endif
                    end
                end
                S_PAYLOAD: begin
                    if (is_load_q) begin
                        pat_we_d    = 1'b1;
                        pat_addr_d  = cnt_q[PAT_AW-1:0];
                        pat_wdata_d = rx_data;
                    end else begin
                        push_req  = 1'b1;
                        push_last = last_byte;
                        if (full) begin
                            err_d      = 1'b1;
                            err_code_d = E_OVERFLOW;
                        end
                    end
                    cnt_d = cnt_q + 8'd1;
`ifdef RX_CMD_CHECKSUM_EN
                    chk_d = chk_q ^ rx_data;
                    if (last_byte) state_d = S_CHK;
`else
                    if (last_byte) begin
                        commit_d = is_load_q;
                        state_d  = S_IDLE;
                    end
`endif
                end
`ifdef RX_CMD_CHECKSUM_EN
                S_CHK: begin
                    if (rx_data == chk_q) begin
                        if (is_load_q) begin
                            pat_valid_d = 1'b1;
                            pat_len_d   = len_q;
                        end
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = 3'd5;
                    end
                    state_d = S_IDLE;
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_s) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rstn_s) begin
            state_q   <= S_IDLE;
            is_load_q <= 1'b0;
            len_q     <= '0;
            cnt_q     <= '0;
            gap_q     <= '0;
            pat_we    <= 1'b0;
            pat_addr  <= '0;
            pat_wdata <= '0;
            pat_len   <= '0;
            pat_valid <= 1'b0;
            err       <= 1'b0;
            err_code  <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
`ifdef RX_CMD_CHECKSUM_EN
            chk_q     <= '0;
`else
            commit_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            is_load_q <= is_load_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            pat_we    <= pat_we_d;
            pat_addr  <= pat_addr_d;
            pat_wdata <= pat_wdata_d;
            pat_len   <= pat_len_d;
            pat_valid <= pat_valid_d;
            err       <= err_d;
            err_code  <= err_code_d;
            if (do_push) wr_q <= wr_q + PTR_ONE;
            if (pop)     rd_q <= rd_q + PTR_ONE;
`ifdef RX_CMD_CHECKSUM_EN
            chk_q     <= chk_d;
`else
            commit_q  <= commit_d;
`endif
        end
    end

    // NOTE: the storage array is not reset; the pointers alone say which entries are valid.
    always_ff @(posedge clk_s) begin
        if (do_push) fifo_mem[wr_q[FIFO_AW-1:0]] <= {push_last, rx_data};
    end

endmodule
